// File: rtl/bp_pkg.sv
// Shared constants and the 2-bit saturating counter step for the fetch-side branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_RESET_DEFAULT = WNT;

    function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cur == ST) ? ST : cur + 2'b01;
        end else begin
            nxt = (cur == SNT) ? SNT : cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Tagged branch target buffer: one combinational read port, one synchronous write port,
// plus a tag probe on the write index so the trainer can detect aliasing.
module bp_btb
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_target,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_target,
    output logic                  wr_hit
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target = rd_hit ? target_q[rd_idx] : 32'h0;
    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor: 2-bit counter table plus tagged BTB, trained from execute.
// Optional performance counters are built when BP_PERF_CNT_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         INDEX_BITS = 6,
    parameter int         TAG_BITS   = 30 - INDEX_BITS,
    parameter logic [1:0] CNT_RESET  = CNT_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredictF,
    output logic [31:0] PredTargetF,
    input  logic        UpdValidE,
    input  logic [31:0] UpdPCE,
    input  logic        UpdTakenE,
    input  logic [31:0] UpdTargetE,
    input  logic        PredCorrectE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [INDEX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0]   f_tag, u_tag;
    logic                  f_hit, u_hit;
    logic [31:0]           f_target;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    assign f_idx = PCF[INDEX_BITS+1:2];
    assign f_tag = PCF[31:INDEX_BITS+2];
    assign u_idx = UpdPCE[INDEX_BITS+1:2];
    assign u_tag = UpdPCE[31:INDEX_BITS+2];

    bp_btb #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_idx),
        .rd_tag    (f_tag),
        .rd_hit    (f_hit),
        .rd_target (f_target),
        .wr_en     (UpdValidE && UpdTakenE),
        .wr_idx    (u_idx),
        .wr_tag    (u_tag),
        .wr_target (UpdTargetE),
        .wr_hit    (u_hit)
    );

    // A taken branch that claims an empty or aliased slot starts fresh at weakly taken.
    always_comb begin
        cnt_d = cnt_q;
        if (UpdValidE) begin
            if (UpdTakenE && !u_hit) begin
                cnt_d[u_idx] = WT;
            end else begin
                cnt_d[u_idx] = cnt_next(cnt_q[u_idx], UpdTakenE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_RESET;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign PredictF    = f_hit && cnt_q[f_idx][1];
    assign PredTargetF = f_target;

`ifdef BP_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (UpdValidE) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (!PredCorrectE) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{PCF[1:0], UpdPCE[1:0]};
`else
    assign BranchCnt  = 32'h0;
    assign MispredCnt = 32'h0;

    logic unused_bits;
    assign unused_bits = ^{PCF[1:0], UpdPCE[1:0], PredCorrectE};
`endif

endmodule
